// File: rtl/spi_flash_program_sequencer.sv
// Autonomous erase / 32-byte page-program sequencer driving the SPI flash custom-instruction port.
// Optional poll timeout enabled by defining SPI_SEQ_POLL_TIMEOUT_EN.
module spi_flash_program_sequencer #(
    parameter logic [7:0]  customInstructionNr = 8'd0,
    parameter logic [15:0] pollInterval        = 16'd64,
    parameter logic [31:0] pollTimeout         = 32'd50000000
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        startIn,
    input  logic        eraseIn,
    input  logic        programIn,
    input  logic [23:0] addressIn,
    input  logic        dataWeIn,
    input  logic [2:0]  dataIdxIn,
    input  logic [31:0] dataIn,
    output logic        busyOut,
    output logic        doneOut,
    output logic [1:0]  errorOut,
    output logic [7:0]  ciN,
    output logic [31:0] ciDataA,
    output logic [31:0] ciDataB,
    output logic        ciStart,
    output logic        ciCke,
    input  logic        ciDone,
    input  logic [31:0] ciResult
);

    typedef enum logic [3:0] {
        IDLE, E_ADDR, E_CMD, E_WAIT, E_POLL,
        P_DATA, P_ADDR, P_CMD, P_WAIT, P_POLL, DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK = 2'b00, ERR_WRITE = 2'b01, ERR_ERASE = 2'b10, ERR_TIMEOUT = 2'b11
    } err_t;

    localparam logic [31:0] SEL_ADDR  = 32'h16;
    localparam logic [31:0] SEL_CTRL  = 32'h07;
    localparam logic [31:0] SEL_DATA0 = 32'h18;

    state_t      state, state_nxt;
    err_t        err_q, err_nxt;
    logic        ci_req;
    logic        ci_state;
    logic        ci_fire;
    logic        wait_end;
    logic        poll_limit;
    logic [2:0]  word_idx;
    logic [15:0] wait_cnt;
    logic        program_q;
    logic [23:0] addr_q;
    logic [31:0] page_buf [8];

    assign ci_state = state inside {E_ADDR, E_CMD, E_POLL, P_DATA, P_ADDR, P_CMD, P_POLL};
    assign ci_fire  = ci_req && ciDone;
    assign wait_end = (wait_cnt == pollInterval - 16'd1);

`ifdef SPI_SEQ_POLL_TIMEOUT_EN
    logic [31:0] poll_cnt;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            poll_cnt <= '0;
        end else if (ci_fire && (state == E_CMD || state == P_CMD)) begin
            poll_cnt <= '0;
        end else if (ci_fire && (state == E_POLL || state == P_POLL)) begin
            poll_cnt <= poll_cnt + 32'd1;
        end
    end

    assign poll_limit = (poll_cnt + 32'd1 == pollTimeout);
`else
    logic unused_timeout;
    assign unused_timeout = ^pollTimeout;
    assign poll_limit     = 1'b0;
`endif

    logic unused_result;
    assign unused_result = ^ciResult[31:3];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            err_q <= ERR_OK;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        case (state)
            IDLE: if (startIn) begin
                err_nxt = ERR_OK;
                if (eraseIn)        state_nxt = E_ADDR;
                else if (programIn) state_nxt = P_DATA;
                else                state_nxt = DONE;
            end
            E_ADDR: if (ci_fire) state_nxt = E_CMD;
            E_CMD:  if (ci_fire) state_nxt = E_WAIT;
            E_WAIT: if (wait_end) state_nxt = E_POLL;
            E_POLL: if (ci_fire) begin
                if (ciResult[0]) begin
                    if (poll_limit) begin
                        state_nxt = DONE;
                        err_nxt   = ERR_TIMEOUT;
                    end else begin
                        state_nxt = E_WAIT;
                    end
                end else if (ciResult[2]) begin
                    state_nxt = DONE;
                    err_nxt   = ERR_ERASE;
                end else begin
                    state_nxt = program_q ? P_DATA : DONE;
                end
            end
            P_DATA: if (ci_fire && word_idx == 3'd7) state_nxt = P_ADDR;
            P_ADDR: if (ci_fire) state_nxt = P_CMD;
            P_CMD:  if (ci_fire) state_nxt = P_WAIT;
            P_WAIT: if (wait_end) state_nxt = P_POLL;
            P_POLL: if (ci_fire) begin
                if (ciResult[0]) begin
                    if (poll_limit) begin
                        state_nxt = DONE;
                        err_nxt   = ERR_TIMEOUT;
                    end else begin
                        state_nxt = P_WAIT;
                    end
                end else begin
                    state_nxt = DONE;
                    err_nxt   = ciResult[1] ? ERR_WRITE : ERR_OK;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request is low on the first cycle of each CI state, giving the mandatory idle gap.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            ci_req    <= 1'b0;
            word_idx  <= '0;
            wait_cnt  <= '0;
            program_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            ci_req   <= ci_state && !ci_fire;
            wait_cnt <= (state == E_WAIT || state == P_WAIT) ? wait_cnt + 16'd1 : 16'd0;
            if (state == P_DATA && ci_fire) word_idx <= word_idx + 3'd1;
            if (state == IDLE && startIn) begin
                program_q <= programIn;
                addr_q    <= addressIn;
            end
        end
    end

    // NOTE: the page buffer is a small register file, so it takes the async reset like any other state.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 8; i++) page_buf[i] <= '0;
        end else if (dataWeIn && !busyOut) begin
            page_buf[dataIdxIn] <= dataIn;
        end
    end

    always_comb begin
        busyOut = (state != IDLE) && (state != DONE);
        doneOut = (state == DONE);
        errorOut = err_q;
        ciStart = ci_req;
        ciDataA = '0;
        ciDataB = '0;
        case (state)
            E_ADDR: begin ciDataB = SEL_ADDR; ciDataA = {8'd0, addr_q}; end
            E_CMD:  begin ciDataB = SEL_CTRL; ciDataA = 32'h2; end
            E_POLL, P_POLL: begin ciDataB = SEL_CTRL; ciDataA = 32'h0; end
            P_DATA: begin ciDataB = SEL_DATA0 + {29'd0, word_idx}; ciDataA = page_buf[word_idx]; end
            P_ADDR: begin ciDataB = SEL_ADDR; ciDataA = {8'd0, addr_q[23:5], 5'd0}; end
            P_CMD:  begin ciDataB = SEL_CTRL; ciDataA = 32'h1; end
            default: ;
        endcase
    end

    assign ciCke = ciStart;
    assign ciN   = customInstructionNr;

endmodule

// File: tb/tb_spi_flash_program_sequencer.sv
// Self-checking bench: vector table of commands, a flash CI model and a transaction scoreboard.
module tb_spi_flash_program_sequencer;

    localparam int         PI    = 8;
    localparam logic [7:0] CI_NR = 8'h5A;
    localparam int         LAT   = 22 + PI + 1;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic        startIn = 1'b0, eraseIn = 1'b0, programIn = 1'b0;
    logic [23:0] addressIn = '0;
    logic        dataWeIn = 1'b0;
    logic [2:0]  dataIdxIn = '0;
    logic [31:0] dataIn = '0;
    logic        busyOut, doneOut, ciStart, ciCke;
    logic [1:0]  errorOut;
    logic [7:0]  ciN;
    logic [31:0] ciDataA, ciDataB;
    logic        ciDone = 1'b0;
    logic [31:0] ciResult = '0;

    spi_flash_program_sequencer #(
        .customInstructionNr(CI_NR),
        .pollInterval(16'(PI)),
        .pollTimeout(32'd4)
    ) dut (
        .clock(clock), .nReset(nReset), .startIn(startIn), .eraseIn(eraseIn),
        .programIn(programIn), .addressIn(addressIn), .dataWeIn(dataWeIn),
        .dataIdxIn(dataIdxIn), .dataIn(dataIn), .busyOut(busyOut), .doneOut(doneOut),
        .errorOut(errorOut), .ciN(ciN), .ciDataA(ciDataA), .ciDataB(ciDataB),
        .ciStart(ciStart), .ciCke(ciCke), .ciDone(ciDone), .ciResult(ciResult)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        er;
        logic        pr;
        logic [23:0] addr;
        int          busy;
        logic [31:0] e_st;
        logic [31:0] p_st;
        int          delay;
        logic        wr;
        logic [2:0]  wr_idx;
        logic [31:0] wr_data;
        int          poke;
        int          max_polls;
        int          lat;
        logic [1:0]  exp_err;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] tbuf [8];
    logic [63:0] exp_q [$];

    int          cur_busy = 0;
    int          cur_delay = 0;
    logic [31:0] cur_e_st = '0;
    logic [31:0] cur_p_st = '0;
    logic        phase_erase = 1'b0;
    int          poll_n = 0;
    int          last_poll = 0;

    always @(posedge clock) cyc_cnt++;
    always @(negedge clock) if (doneOut) done_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void push_expected(input vec_t v);
        int n;
        n = (v.max_polls != 0) ? v.max_polls : v.busy + 1;
        if (v.er) begin
            exp_q.push_back({32'h16, 8'd0, v.addr});
            exp_q.push_back({32'h07, 32'h2});
            for (int i = 0; i < n; i++) exp_q.push_back({32'h07, 32'h0});
            if (v.e_st[2]) return;
        end
        if (v.pr) begin
            for (int k = 0; k < 8; k++) exp_q.push_back({32'h18 + 32'(k), tbuf[k]});
            exp_q.push_back({32'h16, 8'd0, v.addr[23:5], 5'd0});
            exp_q.push_back({32'h07, 32'h1});
            for (int i = 0; i < n; i++) exp_q.push_back({32'h07, 32'h0});
        end
    endfunction

    // Flash CI slave model: answers after cur_delay cycles and checks the handshake rules.
    initial begin
        logic [31:0] b, a, resp;
        logic        ok;
        forever begin
            @(negedge clock);
            if (nReset && ciStart && !ciDone) begin
                b = ciDataB;
                a = ciDataA;
                check("ci_cke", {63'd0, ciCke}, 64'd1);
                check("sb_pending", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) check("ci_txn", {b, a}, exp_q.pop_front());
                resp = '0;
                if (b == 32'h07 && a == 32'h2) begin phase_erase = 1'b1; poll_n = 0; end
                if (b == 32'h07 && a == 32'h1) begin phase_erase = 1'b0; poll_n = 0; end
                if (b == 32'h07 && a == 32'h0) begin
                    poll_n++;
                    if (poll_n > 1) check("poll_space", {63'd0, (cyc_cnt - last_poll) >= PI}, 64'd1);
                    last_poll = cyc_cnt;
                    resp = (poll_n <= cur_busy) ? 32'h1 : (phase_erase ? cur_e_st : cur_p_st);
                end
                ok = 1'b1;
                for (int i = 0; i < cur_delay; i++) begin
                    @(negedge clock);
                    if (!nReset) begin ok = 1'b0; break; end
                    check("ci_stable", {ciStart, ciDataB[30:0], ciDataA}, {1'b1, b[30:0], a});
                end
                if (ok) begin
                    ciResult = resp;
                    ciDone = 1'b1;
                    @(negedge clock);
                    ciDone = 1'b0;
                    ciResult = '0;
                    if (nReset) check("ci_gap", {63'd0, ciStart}, 64'd0);
                end
            end
        end
    end

    task automatic write_word(input logic [2:0] idx, input logic [31:0] data);
        @(negedge clock);
        dataWeIn = 1'b1; dataIdxIn = idx; dataIn = data;
        tbuf[idx] = data;
        @(negedge clock);
        dataWeIn = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        cur_busy = v.busy; cur_delay = v.delay; cur_e_st = v.e_st; cur_p_st = v.p_st;
        if (v.wr) tbuf[v.wr_idx] = v.wr_data;
        push_expected(v);
        done_cnt = 0;
        @(negedge clock);
        eraseIn = v.er; programIn = v.pr; addressIn = v.addr; startIn = 1'b1;
        dataWeIn = v.wr; dataIdxIn = v.wr_idx; dataIn = v.wr_data;
        @(negedge clock);
        startIn = 1'b0; eraseIn = 1'b0; programIn = 1'b0; dataWeIn = 1'b0;
        cyc = 1;
        if (v.er || v.pr) check($sformatf("v%0d_busy", idx), {63'd0, busyOut}, 64'd1);
        while (!doneOut && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            startIn = 1'b0; eraseIn = 1'b0; programIn = 1'b0; dataWeIn = 1'b0;
            if (cyc == v.poke) begin
                startIn = 1'b1; eraseIn = 1'b1; programIn = 1'b1;
                dataWeIn = 1'b1; dataIdxIn = 3'd7; dataIn = 32'hDEADBEEF;
            end
        end
        startIn = 1'b0; eraseIn = 1'b0; programIn = 1'b0; dataWeIn = 1'b0;
        check($sformatf("v%0d_done", idx), {63'd0, doneOut}, 64'd1);
        check($sformatf("v%0d_err", idx), {62'd0, errorOut}, {62'd0, v.exp_err});
        check($sformatf("v%0d_busy_done", idx), {63'd0, busyOut}, 64'd0);
        if (v.lat != 0) check($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.lat));
        repeat (3) @(negedge clock);
        check($sformatf("v%0d_done_once", idx), 64'(done_cnt), 64'd1);
        check($sformatf("v%0d_err_held", idx), {62'd0, errorOut}, {62'd0, v.exp_err});
        check($sformatf("v%0d_sb_drained", idx), 64'(exp_q.size()), 64'd0);
    endtask

    vec_t vecs [8];

    initial begin
        vec_t v;
        bit   found;

        vecs[0] = '{1'b0, 1'b1, 24'h012345, 3, 32'h0, 32'h0, 0, 1'b0, 3'd0, 32'h0, 0, 0, 0, 2'b00};
        vecs[1] = '{1'b1, 1'b1, 24'h020000, 0, 32'h4, 32'h0, 0, 1'b0, 3'd0, 32'h0, 0, 0, 0, 2'b10};
        vecs[2] = '{1'b0, 1'b1, 24'h000100, 0, 32'h0, 32'h2, 0, 1'b0, 3'd0, 32'h0, 0, 0, LAT, 2'b01};
        vecs[3] = '{1'b0, 1'b1, 24'h00FF00, 1, 32'h0, 32'h0, 5, 1'b0, 3'd0, 32'h0, 0, 0, 0, 2'b00};
        vecs[4] = '{1'b1, 1'b0, 24'h0ABCDE, 2, 32'h0, 32'h0, 0, 1'b0, 3'd0, 32'h0, 0, 0, 0, 2'b00};
        vecs[5] = '{1'b1, 1'b1, 24'h0FFFFF, 0, 32'h0, 32'h0, 0, 1'b0, 3'd0, 32'h0, 0, 0, 0, 2'b00};
        vecs[6] = '{1'b0, 1'b0, 24'h000000, 0, 32'h0, 32'h0, 0, 1'b0, 3'd0, 32'h0, 0, 0, 1, 2'b00};
        vecs[7] = '{1'b0, 1'b1, 24'h123456, 0, 32'h0, 32'h0, 0, 1'b1, 3'd0, 32'hCAFEF00D, 6, 0, LAT, 2'b00};

        for (int k = 0; k < 8; k++) tbuf[k] = '0;

        repeat (2) @(negedge clock);
        check("rst_busy", {63'd0, busyOut}, 64'd0);
        check("rst_done", {63'd0, doneOut}, 64'd0);
        check("rst_err", {62'd0, errorOut}, 64'd0);
        check("rst_start", {62'd0, ciStart, ciCke}, 64'd0);
        check("rst_data", {ciDataB, ciDataA}, 64'd0);
        check("rst_ciN", {56'd0, ciN}, {56'd0, CI_NR});
        #2 nReset = 1'b1;

        for (int k = 0; k < 8; k++) write_word(3'(k), 32'h11111111 * 32'(k + 1));

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of the page-data phase, then a clean rerun from an empty buffer.
        v = '{1'b0, 1'b1, 24'h000200, 0, 32'h0, 32'h0, 3, 1'b0, 3'd0, 32'h0, 0, 0, 0, 2'b00};
        cur_busy = 0; cur_delay = 3;
        push_expected(v);
        @(negedge clock);
        programIn = 1'b1; addressIn = v.addr; startIn = 1'b1;
        @(negedge clock);
        startIn = 1'b0; programIn = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (ciStart && ciDataB == 32'h1B) found = 1'b1;
            else @(negedge clock);
        end
        check("rst_reach_k3", {63'd0, found}, 64'd1);
        #2 nReset = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busyOut}, 64'd0);
        check("midrst_start", {62'd0, ciStart, ciCke}, 64'd0);
        check("midrst_err", {62'd0, errorOut}, 64'd0);
        exp_q.delete();
        for (int k = 0; k < 8; k++) tbuf[k] = '0;
        @(negedge clock);
        #2 nReset = 1'b1;
        v.delay = 0;
        run_vec(v, 8);

`ifdef SPI_SEQ_POLL_TIMEOUT_EN
        v = '{1'b0, 1'b1, 24'h000040, 1000, 32'h0, 32'h0, 0, 1'b0, 3'd0, 32'h0, 0, 4, 0, 2'b11};
        run_vec(v, 9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
